// File: rtl/fft4_pkg.sv
// Shared constants for the 4-point real FFT sequencer: FSM encoding, default width, bin order.
package fft4_pkg;

  localparam int W_DEF = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_BF1  = 3'd1;
  localparam state_t ST_BF2  = 3'd2;
  localparam state_t ST_BF3  = 3'd3;
  localparam state_t ST_OUT  = 3'd4;

  localparam logic [1:0] BIN_X0   = 2'd0;
  localparam logic [1:0] BIN_X1   = 2'd1;
  localparam logic [1:0] BIN_X2   = 2'd2;
  localparam logic [1:0] BIN_X3   = 2'd3;
  localparam logic [1:0] BIN_LAST = BIN_X3;

endpackage

// File: rtl/fft4_bfly.sv
// Radix-2 add/subtract butterfly; combinational, no flow control.
// Computes in W+1 bits, then either wraps to W bits or halves (SCALE=1).
module fft4_bfly #(
  parameter int W     = 16,
  parameter int SCALE = 0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic [W-1:0] diff
);

  logic [W:0] s_ext;
  logic [W:0] d_ext;

  assign s_ext = {a[W-1], a} + {b[W-1], b};
  assign d_ext = {a[W-1], a} - {b[W-1], b};

  assign sum  = (SCALE != 0) ? s_ext[W:1] : s_ext[W-1:0];
  assign diff = (SCALE != 0) ? d_ext[W:1] : d_ext[W-1:0];

endmodule

// File: rtl/fft4_seq_ctrl.sv
// 4-point real FFT on one shared butterfly: load 4 samples, 3 butterfly passes, emit 4 bins.
// Bin 0 valid 3 edges after the 4th sample; output regs hold while out_ready is low.
module fft4_seq_ctrl
  import fft4_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int SCALE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_re,
  output logic [W-1:0] out_im,
  output logic [1:0]   out_idx,
  output logic         out_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  state_t       state;
  state_t       state_nxt;
  logic [1:0]   cnt;
  logic [W-1:0] x [4];
  logic [W-1:0] a0, a1, b0, b1, xf0, xf2;
  logic [W-1:0] op_a, op_b, bf_sum, bf_diff;
  logic [W-1:0] neg_b1;
  logic [1:0]   nxt_idx;
  logic [W-1:0] nxt_re, nxt_im;
  logic         accept_in, accept_out;

  assign accept_in  = in_valid & in_ready;
  assign accept_out = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept_in && cnt == 2'd3) state_nxt = ST_BF1;
      ST_BF1:  state_nxt = ST_BF2;
      ST_BF2:  state_nxt = ST_BF3;
      ST_BF3:  state_nxt = ST_OUT;
      ST_OUT:  if (accept_out && out_last) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready = (state == ST_IDLE);
    busy     = (state != ST_IDLE);
  end

  // Butterfly operand select for each pass
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state)
      ST_BF1: begin op_a = x[0]; op_b = x[2]; end
      ST_BF2: begin op_a = x[1]; op_b = x[3]; end
      ST_BF3: begin op_a = a0;   op_b = b0;   end
      default: ;
    endcase
  end

  fft4_bfly #(.W(W), .SCALE(SCALE)) u_bfly (
    .a    (op_a),
    .b    (op_b),
    .sum  (bf_sum),
    .diff (bf_diff)
  );

  // Most-negative b1 negates to itself, which is the intended wrap
  assign neg_b1  = '0 - b1;
  assign nxt_idx = out_idx + 2'd1;

  always_comb begin
    nxt_re = xf0;
    nxt_im = '0;
    case (nxt_idx)
      BIN_X1: begin nxt_re = a1;  nxt_im = neg_b1; end
      BIN_X2: begin nxt_re = xf2; nxt_im = '0;     end
      BIN_X3: begin nxt_re = a1;  nxt_im = b1;     end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      for (int i = 0; i < 4; i++) x[i] <= '0;
      a0        <= '0;
      a1        <= '0;
      b0        <= '0;
      b1        <= '0;
      xf0       <= '0;
      xf2       <= '0;
      out_re    <= '0;
      out_im    <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept_in) begin
            x[cnt] <= in_data;
            cnt    <= (cnt == 2'd3) ? 2'd0 : cnt + 2'd1;
          end
        end
        ST_BF1: begin
          a0 <= bf_sum;
          a1 <= bf_diff;
        end
        ST_BF2: begin
          b0 <= bf_sum;
          b1 <= bf_diff;
        end
        ST_BF3: begin
          xf0       <= bf_sum;
          xf2       <= bf_diff;
          out_re    <= bf_sum;
          out_im    <= '0;
          out_idx   <= BIN_X0;
          out_last  <= 1'b0;
          out_valid <= 1'b1;
        end
        ST_OUT: begin
          if (accept_out) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_re    <= '0;
              out_im    <= '0;
              out_idx   <= '0;
              out_last  <= 1'b0;
            end else begin
              out_re   <= nxt_re;
              out_im   <= nxt_im;
              out_idx  <= nxt_idx;
              out_last <= (nxt_idx == BIN_LAST);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fft4_seq_ctrl.md
# fft4_seq_ctrl

Sequencing controller for a 4-point real-input radix-2 FFT built around one shared add/subtract butterfly. It accepts four time-domain samples over a valid/ready stream, reuses the single butterfly for three passes, and streams four complex frequency bins out over a second valid/ready stream. It sits between the sample source and the spectrum consumer in the FFT datapath, replacing four parallel butterflies with one.

## Interface
- `W`, 16: sample/result width, two's complement.
- `SCALE`, 0: 0 = wrap each butterfly result to `W` bits; 1 = compute in `W+1` bits and arithmetic-shift right by 1 per butterfly.
- `clk` input 1: clock, rising-edge.
- `rst_n` input 1: reset; one clock, asynchronous, active-low.
- `in_data` input W: time sample, x0 first.
- `in_valid` input 1: `in_data` valid.
- `in_ready` output 1: controller can accept a sample.
- `out_re` output W: real part of current bin.
- `out_im` output W: imaginary part of current bin.
- `out_idx` output 2: bin index 0..3.
- `out_last` output 1: high with bin 3.
- `out_valid` output 1: bin valid.
- `out_ready` input 1: consumer accepts bin.
- `busy` output 1: high in any state other than IDLE.

## Operation
- States: IDLE, BF1, BF2, BF3, OUT.
- IDLE: `in_ready`=1. Each accept (`in_valid&in_ready` at a rising edge) writes `x[cnt]`, `cnt`++. Accepting the 4th sample → BF1, `cnt`←0.
- BF1: butterfly(x0,x2) → a0=x0+x2, a1=x0−x2. → BF2.
- BF2: butterfly(x1,x3) → b0=x1+x3, b1=x1−x3. → BF3.
- BF3: butterfly(a0,b0) → X0=a0+b0, X2=a0−b0. → OUT.
- OUT: bins in order 0..3: X0=(X0,0), X1=(a1,−b1), X2=(X2,0), X3=(a1,b1). `out_idx` advances on each accept; accepting bin 3 → IDLE.
- Arithmetic: sum/difference formed in W+1 bits. SCALE=0 keeps bits [W−1:0]; SCALE=1 keeps bits [W:1] (arithmetic shift).
- −b1 is two's-complement negation in W bits. Negating the most-negative value wraps to itself.
- `in_valid` during BF1..OUT is ignored because `in_ready`=0. No sample is lost or buffered.
- Input gaps (`in_valid`=0) stall collection indefinitely, with no timeout.

## Timing
- Reset values: state IDLE, `cnt`=0, `in_ready`=1, `out_valid`=0, `out_re`=`out_im`=0, `out_idx`=0, `out_last`=0, `busy`=0. All sample and intermediate registers are 0.
- If the 4th sample is accepted at edge k: BF1 after k, BF2 after k+1, BF3 after k+2, and `out_valid`=1 with bin 0 after edge k+3.
- Output handshake: while `out_valid`&!`out_ready`, `out_re`/`out_im`/`out_idx`/`out_last` stay stable. With `out_ready` held high, one bin is issued per cycle.
- Bin 3 is accepted at edge m. After m the state is IDLE, `out_valid`=0 and `in_ready`=1. The first sample of the next block can be accepted at edge m+1.
- Minimum block period with no stalls: 4 (load) + 3 (compute) + 4 (output) = 11 cycles.
- `rst_n` low at any time (mid-load, mid-compute, mid-output): all state returns immediately to reset values. The partial block is discarded.

## Structure
- Package `fft4_pkg` holds:
  - state encoding localparams;
  - the default `W`;
  - the bin-order constants.
- One sub-module, `fft4_bfly` (parameters W, SCALE; inputs a, b; outputs sum, diff), is instantiated once. Its operand muxes are driven by the FSM.
- All outputs are driven from registers. `in_ready` and `busy` may be decoded from the state register.

## Test plan
- Ramp: SCALE=0, samples 1,2,3,4 → bins (10,0), (−2,2), (−2,0), (−2,−2); `out_last` high only on bin 3; `out_valid` rises 3 edges after the 4th accept.
- Overflow: four samples of 32767 → SCALE=0 gives X0=(−4,0), other bins 0. SCALE=1 gives X0=(32767,0), other bins 0.
- Negation wrap: SCALE=0, x0=0, x1=−32768, x2=0, x3=0 → X1 and X3 both equal (0,−32768); X0=(−32768,0), X2=(−32768,0).
- Backpressure and gaps:
  - drive `in_valid` in a 1-0-1-1-0-1 pattern → exactly 4 samples are captured;
  - hold `out_ready` low for 5 cycles while bin 1 is presented → bin 1 stays stable, and no bin is skipped or repeated;
  - raise `in_valid` during OUT → `in_ready` stays 0 and the result is unaffected.
- Reset mid-output: pull `rst_n` low while bin 2 is presented → all outputs return to reset values at once. After release, samples 5,6,7,8 give bins (26,0), (−2,2), (−2,0), (−2,−2).
- Back-to-back: two blocks with `out_ready` held high → first sample of block 2 is accepted exactly one edge after bin 3 of block 1; period is 11 cycles.
